// File: rtl/agc_stats_engine.sv
// Multi-channel AGC measurement engine: per-channel windowed sum of squares and
// threshold-crossing counts, latched into a result bank read out by channel index.
module agc_stats_engine #(
    parameter int unsigned NCHAN       = 8,
    parameter int unsigned NSAMP       = 8,
    parameter int unsigned NBITS       = 12,
    parameter int unsigned SQ_ACC_BITS = 32,
    parameter int unsigned CNT_BITS    = 24,
    parameter int unsigned PIPE_LAT    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NCHAN*NSAMP*NBITS-1:0] dat_i,
    input  logic                         dat_valid_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         continuous_i,
    input  logic [4:0]                   win_log2_i,
    input  logic [NBITS-2:0]             threshold_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [7:0]                   seq_o,
    output logic [NCHAN-1:0]             sat_o,
    input  logic [$clog2(NCHAN)-1:0]     rd_chan_i,
    output logic [SQ_ACC_BITS-1:0]       rd_sq_o,
    output logic [CNT_BITS-1:0]          rd_gt_o,
    output logic [CNT_BITS-1:0]          rd_lt_o
);

    localparam int unsigned SQ_W     = 2 * NBITS - 1;
    localparam int unsigned CHW      = $clog2(NCHAN);
    localparam int unsigned BSW      = $clog2(NSAMP + 1);
    localparam int unsigned SQ_SUM_W = SQ_W + BSW;
    localparam int unsigned SQ_EXT   = ((SQ_ACC_BITS > SQ_SUM_W) ? SQ_ACC_BITS : SQ_SUM_W) + 1;
    localparam int unsigned CNT_EXT  = ((CNT_BITS > BSW) ? CNT_BITS : BSW) + 1;
    localparam int unsigned FLW      = $clog2(PIPE_LAT + 1);
    localparam int unsigned BCW      = 21;
    localparam logic [4:0]  WIN_MAX  = 5'd20;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StLatch} state_e;

    state_e                  state_q, state_d;
    logic                    cont_q, cont_d;
    logic [4:0]              win_q, win_d;
    logic [NBITS-2:0]        thr_q, thr_d;
    logic                    stop_pend_q, stop_pend_d;
    logic [BCW-1:0]          beat_q, beat_d;
    logic [FLW-1:0]          flush_q, flush_d;
    logic                    done_q, done_d;
    logic [7:0]              seq_q, seq_d;
    logic [NCHAN-1:0]        sat_q, sat_d;
    logic [BCW-1:0]          win_target;
    logic                    acc_clr, latch_en, beat_take;

    // Three-stage datapath: capture, square/compare, per-channel reduce.
    logic [NCHAN*NSAMP*NBITS-1:0]              s1_dat_q, s1_dat_d;
    logic                                      s1_vld_q, s1_vld_d;
    logic [NCHAN-1:0][NSAMP-1:0][SQ_W-1:0]     s2_sq_q, s2_sq_d;
    logic [NCHAN-1:0][NSAMP-1:0]               s2_gt_q, s2_gt_d;
    logic [NCHAN-1:0][NSAMP-1:0]               s2_lt_q, s2_lt_d;
    logic                                      s2_vld_q, s2_vld_d;
    logic [NCHAN-1:0][SQ_SUM_W-1:0]            s3_sq_q, s3_sq_d;
    logic [NCHAN-1:0][BSW-1:0]                 s3_gt_q, s3_gt_d;
    logic [NCHAN-1:0][BSW-1:0]                 s3_lt_q, s3_lt_d;
    logic                                      s3_vld_q, s3_vld_d;

    logic [NCHAN-1:0][SQ_ACC_BITS-1:0] acc_sq_q, acc_sq_d;
    logic [NCHAN-1:0][CNT_BITS-1:0]    acc_gt_q, acc_gt_d;
    logic [NCHAN-1:0][CNT_BITS-1:0]    acc_lt_q, acc_lt_d;
    logic [NCHAN-1:0]                  acc_sat_q, acc_sat_d;
    logic [NCHAN-1:0][SQ_ACC_BITS:0]   sum_sq;
    logic [NCHAN-1:0][CNT_BITS:0]      sum_gt, sum_lt;

    logic [NCHAN-1:0][SQ_ACC_BITS-1:0] bank_sq_q, bank_sq_d;
    logic [NCHAN-1:0][CNT_BITS-1:0]    bank_gt_q, bank_gt_d;
    logic [NCHAN-1:0][CNT_BITS-1:0]    bank_lt_q, bank_lt_d;
    logic [SQ_ACC_BITS-1:0]            rd_sq_q, rd_sq_d;
    logic [CNT_BITS-1:0]               rd_gt_q, rd_gt_d;
    logic [CNT_BITS-1:0]               rd_lt_q, rd_lt_d;

    logic signed [NBITS:0] thr_pos, thr_neg;

    function automatic logic [SQ_W-1:0] square(input logic [NBITS-1:0] v);
        logic [2*NBITS-1:0] w;
        logic [2*NBITS-1:0] p;
        w = {{NBITS{v[NBITS-1]}}, v};
        p = w * w;
        return p[SQ_W-1:0];
    endfunction

    function automatic logic signed [NBITS:0] sext(input logic [NBITS-1:0] v);
        return $signed({v[NBITS-1], v});
    endfunction

    // Top bit of the result flags an overflow; the value is then clamped to all-ones.
    function automatic logic [SQ_ACC_BITS:0] add_sq(input logic [SQ_ACC_BITS-1:0] a,
                                                    input logic [SQ_SUM_W-1:0]    b);
        logic [SQ_EXT-1:0] t;
        t = SQ_EXT'(a) + SQ_EXT'(b);
        if (t[SQ_EXT-1:SQ_ACC_BITS] != '0) return {1'b1, {SQ_ACC_BITS{1'b1}}};
        return {1'b0, t[SQ_ACC_BITS-1:0]};
    endfunction

    function automatic logic [CNT_BITS:0] add_cnt(input logic [CNT_BITS-1:0] a,
                                                  input logic [BSW-1:0]      b);
        logic [CNT_EXT-1:0] t;
        t = CNT_EXT'(a) + CNT_EXT'(b);
        if (t[CNT_EXT-1:CNT_BITS] != '0) return {1'b1, {CNT_BITS{1'b1}}};
        return {1'b0, t[CNT_BITS-1:0]};
    endfunction

    assign win_target = BCW'(1) << win_q;
    assign thr_pos    = $signed({2'b00, thr_q});
    assign thr_neg    = -thr_pos;

    always_comb begin
        state_d     = state_q;
        cont_d      = cont_q;
        win_d       = win_q;
        thr_d       = thr_q;
        stop_pend_d = stop_pend_q;
        beat_d      = beat_q;
        flush_d     = flush_q;
        done_d      = 1'b0;
        seq_d       = seq_q;
        acc_clr     = 1'b0;
        latch_en    = 1'b0;
        beat_take   = 1'b0;
        unique case (state_q)
            StIdle: begin
                stop_pend_d = 1'b0;
                if (start_i) begin
                    cont_d      = continuous_i;
                    win_d       = (win_log2_i > WIN_MAX) ? WIN_MAX : win_log2_i;
                    thr_d       = threshold_i;
                    stop_pend_d = stop_i;
                    beat_d      = '0;
                    acc_clr     = 1'b1;
                    state_d     = StRun;
                end
            end
            StRun: begin
                stop_pend_d = stop_pend_q | stop_i;
                if (dat_valid_i) begin
                    beat_take = 1'b1;
                    beat_d    = beat_q + BCW'(1);
                    if (beat_d == win_target) begin
                        flush_d = '0;
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                stop_pend_d = stop_pend_q | stop_i;
                flush_d     = flush_q + FLW'(1);
                if (flush_q == FLW'(PIPE_LAT - 1)) state_d = StLatch;
            end
            StLatch: begin
                stop_pend_d = stop_pend_q | stop_i;
                latch_en    = 1'b1;
                acc_clr     = 1'b1;
                done_d      = 1'b1;
                seq_d       = seq_q + 8'd1;
                beat_d      = '0;
                state_d     = (cont_q && !stop_pend_q && !stop_i) ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s1_dat_d = dat_i;
        s1_vld_d = beat_take;
        s2_vld_d = s1_vld_q;
        s3_vld_d = s2_vld_q;
        s2_sq_d  = '0;
        s2_gt_d  = '0;
        s2_lt_d  = '0;
        s3_sq_d  = '0;
        s3_gt_d  = '0;
        s3_lt_d  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            for (int s = 0; s < NSAMP; s++) begin
                s2_sq_d[c][s] = square(s1_dat_q[(c*NSAMP+s)*NBITS +: NBITS]);
                s2_gt_d[c][s] = sext(s1_dat_q[(c*NSAMP+s)*NBITS +: NBITS]) > thr_pos;
                s2_lt_d[c][s] = sext(s1_dat_q[(c*NSAMP+s)*NBITS +: NBITS]) < thr_neg;
                s3_sq_d[c]    = s3_sq_d[c] + SQ_SUM_W'(s2_sq_q[c][s]);
                s3_gt_d[c]    = s3_gt_d[c] + BSW'(s2_gt_q[c][s]);
                s3_lt_d[c]    = s3_lt_d[c] + BSW'(s2_lt_q[c][s]);
            end
        end
    end

    always_comb begin
        acc_sq_d  = acc_sq_q;
        acc_gt_d  = acc_gt_q;
        acc_lt_d  = acc_lt_q;
        acc_sat_d = acc_sat_q;
        sum_sq    = '0;
        sum_gt    = '0;
        sum_lt    = '0;
        for (int c = 0; c < NCHAN; c++) begin
            sum_sq[c] = add_sq(acc_sq_q[c], s3_sq_q[c]);
            sum_gt[c] = add_cnt(acc_gt_q[c], s3_gt_q[c]);
            sum_lt[c] = add_cnt(acc_lt_q[c], s3_lt_q[c]);
            if (acc_clr) begin
                acc_sq_d[c]  = '0;
                acc_gt_d[c]  = '0;
                acc_lt_d[c]  = '0;
                acc_sat_d[c] = 1'b0;
            end else if (s3_vld_q) begin
                acc_sq_d[c]  = sum_sq[c][SQ_ACC_BITS-1:0];
                acc_gt_d[c]  = sum_gt[c][CNT_BITS-1:0];
                acc_lt_d[c]  = sum_lt[c][CNT_BITS-1:0];
                acc_sat_d[c] = acc_sat_q[c] | sum_sq[c][SQ_ACC_BITS] |
                               sum_gt[c][CNT_BITS] | sum_lt[c][CNT_BITS];
            end
        end
    end

    always_comb begin
        bank_sq_d = latch_en ? acc_sq_q : bank_sq_q;
        bank_gt_d = latch_en ? acc_gt_q : bank_gt_q;
        bank_lt_d = latch_en ? acc_lt_q : bank_lt_q;
        sat_d     = latch_en ? acc_sat_q : sat_q;
        // Indices with no bank entry fall through to zero.
        rd_sq_d   = '0;
        rd_gt_d   = '0;
        rd_lt_d   = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (rd_chan_i == CHW'(c)) begin
                rd_sq_d = bank_sq_q[c];
                rd_gt_d = bank_gt_q[c];
                rd_lt_d = bank_lt_q[c];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cont_q      <= 1'b0;
            win_q       <= '0;
            thr_q       <= '0;
            stop_pend_q <= 1'b0;
            beat_q      <= '0;
            flush_q     <= '0;
            done_q      <= 1'b0;
            seq_q       <= '0;
            sat_q       <= '0;
            s1_dat_q    <= '0;
            s1_vld_q    <= 1'b0;
            s2_sq_q     <= '0;
            s2_gt_q     <= '0;
            s2_lt_q     <= '0;
            s2_vld_q    <= 1'b0;
            s3_sq_q     <= '0;
            s3_gt_q     <= '0;
            s3_lt_q     <= '0;
            s3_vld_q    <= 1'b0;
            acc_sq_q    <= '0;
            acc_gt_q    <= '0;
            acc_lt_q    <= '0;
            acc_sat_q   <= '0;
            bank_sq_q   <= '0;
            bank_gt_q   <= '0;
            bank_lt_q   <= '0;
            rd_sq_q     <= '0;
            rd_gt_q     <= '0;
            rd_lt_q     <= '0;
        end else begin
            state_q     <= state_d;
            cont_q      <= cont_d;
            win_q       <= win_d;
            thr_q       <= thr_d;
            stop_pend_q <= stop_pend_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
            seq_q       <= seq_d;
            sat_q       <= sat_d;
            s1_dat_q    <= s1_dat_d;
            s1_vld_q    <= s1_vld_d;
            s2_sq_q     <= s2_sq_d;
            s2_gt_q     <= s2_gt_d;
            s2_lt_q     <= s2_lt_d;
            s2_vld_q    <= s2_vld_d;
            s3_sq_q     <= s3_sq_d;
            s3_gt_q     <= s3_gt_d;
            s3_lt_q     <= s3_lt_d;
            s3_vld_q    <= s3_vld_d;
            acc_sq_q    <= acc_sq_d;
            acc_gt_q    <= acc_gt_d;
            acc_lt_q    <= acc_lt_d;
            acc_sat_q   <= acc_sat_d;
            bank_sq_q   <= bank_sq_d;
            bank_gt_q   <= bank_gt_d;
            bank_lt_q   <= bank_lt_d;
            rd_sq_q     <= rd_sq_d;
            rd_gt_q     <= rd_gt_d;
            rd_lt_q     <= rd_lt_d;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;
    assign seq_o   = seq_q;
    assign sat_o   = sat_q;
    assign rd_sq_o = rd_sq_q;
    assign rd_gt_o = rd_gt_q;
    assign rd_lt_o = rd_lt_q;

endmodule

// File: tb/tb_agc_stats_engine.sv
// Directed bench for agc_stats_engine: a default build plus a 6-channel,
// 24-bit-accumulator build driven from the same stimulus.
module tb_agc_stats_engine;

    localparam int NCHAN  = 8;
    localparam int NSAMP  = 8;
    localparam int NBITS  = 12;
    localparam int DW     = NCHAN * NSAMP * NBITS;
    localparam int NCHAN2 = 6;
    localparam int DW2    = NCHAN2 * NSAMP * NBITS;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [DW-1:0]     dat;
    logic              dat_valid_i, start_i, stop_i, continuous_i;
    logic [4:0]        win_log2_i;
    logic [NBITS-2:0]  threshold_i;
    logic              busy_o, done_o;
    logic [7:0]        seq_o;
    logic [NCHAN-1:0]  sat_o;
    logic [2:0]        rd_chan;
    logic [31:0]       rd_sq_o;
    logic [23:0]       rd_gt_o, rd_lt_o;

    logic              busy2, done2;
    logic [7:0]        seq2;
    logic [NCHAN2-1:0] sat2;
    logic [2:0]        rd_chan2;
    logic [23:0]       rd_sq2, rd_gt2, rd_lt2;

    int n_pass  = 0;
    int n_total = 0;
    int seq_exp = 0;

    always #5 clk = ~clk;

    agc_stats_engine u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dat_i       (dat),
        .dat_valid_i (dat_valid_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .continuous_i(continuous_i),
        .win_log2_i  (win_log2_i),
        .threshold_i (threshold_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .seq_o       (seq_o),
        .sat_o       (sat_o),
        .rd_chan_i   (rd_chan),
        .rd_sq_o     (rd_sq_o),
        .rd_gt_o     (rd_gt_o),
        .rd_lt_o     (rd_lt_o)
    );

    agc_stats_engine #(
        .NCHAN      (NCHAN2),
        .SQ_ACC_BITS(24)
    ) u_dut_small (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .dat_i       (dat[DW2-1:0]),
        .dat_valid_i (dat_valid_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .continuous_i(continuous_i),
        .win_log2_i  (win_log2_i),
        .threshold_i (threshold_i),
        .busy_o      (busy2),
        .done_o      (done2),
        .seq_o       (seq2),
        .sat_o       (sat2),
        .rd_chan_i   (rd_chan2),
        .rd_sq_o     (rd_sq2),
        .rd_gt_o     (rd_gt2),
        .rd_lt_o     (rd_lt2)
    );

    typedef struct {
        int     win;
        int     thr;
        int     ch;
        int     val;
        bit     tog;
        int     lat;
        int     rch;
        longint sq;
        int     gt;
        int     lt;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic set_chan(input int ch, input int val);
        logic [NBITS-1:0] v;
        v   = NBITS'(val);
        dat = '0;
        for (int s = 0; s < NSAMP; s++) dat[(ch*NSAMP+s)*NBITS +: NBITS] = v;
    endtask

    task automatic read_bank(input int ch, input int ch2);
        rd_chan  = 3'(ch);
        rd_chan2 = 3'(ch2);
        tick();
    endtask

    // Returns the tick count from the start tick (counted as 1) to the done_o tick.
    task automatic run_win(input int win, input int thr, input bit cont, input bit tog,
                           input int extra, output int lat);
        win_log2_i   = 5'(win);
        threshold_i  = 11'(thr);
        continuous_i = cont;
        start_i      = 1'b1;
        dat_valid_i  = 1'b1;
        tick();
        start_i = 1'b0;
        lat     = 1;
        while (!done_o && lat < 200) begin
            dat_valid_i = tog ? (lat % 2 == 1) : 1'b1;
            if (lat == extra) begin
                start_i    = 1'b1;
                win_log2_i = 5'd0;
            end else begin
                start_i = 1'b0;
            end
            tick();
            lat++;
        end
        start_i     = 1'b0;
        dat_valid_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cyc;
        int ndone;
        int t_done[3];

        vecs[0] = '{2, 50, 0, 100, 1'b0, 9, 0, 64'd320000, 32, 0};
        vecs[1] = '{2, 50, 0, 100, 1'b0, 9, 3, 64'd0, 0, 0};
        vecs[2] = '{3, 2047, 5, -2048, 1'b1, 20, 5, 64'd268435456, 0, 64};
        vecs[3] = '{0, 0, 7, 1, 1'b0, 6, 7, 64'd8, 8, 0};
        vecs[4] = '{1, 5, 2, -5, 1'b0, 7, 2, 64'd400, 0, 0};
        vecs[5] = '{1, 4, 2, -5, 1'b0, 7, 2, 64'd400, 0, 16};
        vecs[6] = '{1, 99, 4, 100, 1'b0, 7, 4, 64'd160000, 16, 0};
        vecs[7] = '{1, 2047, 6, 2047, 1'b1, 8, 6, 64'd67043344, 0, 0};

        rst_i        = 1'b1;
        dat          = '0;
        dat_valid_i  = 1'b0;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        continuous_i = 1'b0;
        win_log2_i   = '0;
        threshold_i  = '0;
        rd_chan      = '0;
        rd_chan2     = '0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_seq", seq_o, 0);
        check("reset_sat", sat_o, 0);
        check("reset_rd_sq", rd_sq_o, 0);
        check("reset_rd_gt", rd_gt_o, 0);
        check("reset_rd_lt", rd_lt_o, 0);

        for (int i = 0; i < 8; i++) begin
            set_chan(vecs[i].ch, vecs[i].val);
            run_win(vecs[i].win, vecs[i].thr, 1'b0, vecs[i].tog, 0, lat);
            seq_exp = (seq_exp + 1) % 256;
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_seq", i), seq_o, seq_exp);
            read_bank(vecs[i].rch, 0);
            check($sformatf("vec%0d_sq", i), rd_sq_o, vecs[i].sq);
            check($sformatf("vec%0d_gt", i), rd_gt_o, vecs[i].gt);
            check($sformatf("vec%0d_lt", i), rd_lt_o, vecs[i].lt);
        end

        // Saturation: only the 24-bit build overflows on two full-scale beats.
        set_chan(1, -2048);
        run_win(1, 0, 1'b0, 1'b0, 0, lat);
        seq_exp = (seq_exp + 1) % 256;
        check("sat_latency", lat, 7);
        check("sat_flag_small", sat2, 6'b000010);
        check("sat_flag_main", sat_o, 0);
        read_bank(1, 1);
        check("sat_sq_small", rd_sq2, 24'hFFFFFF);
        check("sat_lt_small", rd_lt2, 16);
        check("nosat_sq_main", rd_sq_o, 67108864);
        for (int r = 6; r < 8; r++) begin
            read_bank(0, r);
            check($sformatf("oob%0d_sq", r), rd_sq2, 0);
            check($sformatf("oob%0d_gt", r), rd_gt2, 0);
            check($sformatf("oob%0d_lt", r), rd_lt2, 0);
        end
        dat = '0;
        run_win(1, 0, 1'b0, 1'b0, 0, lat);
        seq_exp = (seq_exp + 1) % 256;
        check("sat_clear_flag", sat2, 0);
        read_bank(1, 1);
        check("sat_clear_sq", rd_sq2, 0);

        // A start pulse mid-window (with a smaller window size) must be ignored.
        set_chan(0, 100);
        run_win(2, 50, 1'b0, 1'b0, 3, lat);
        seq_exp = (seq_exp + 1) % 256;
        check("ign_start_latency", lat, 9);
        check("ign_start_seq", seq_o, seq_exp);
        read_bank(0, 0);
        check("ign_start_sq", rd_sq_o, 320000);

        // Asynchronous reset mid-run.
        win_log2_i   = 5'd2;
        threshold_i  = 11'd50;
        continuous_i = 1'b0;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check("rst_busy_before", busy_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_seq", seq_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_rd_sq", rd_sq_o, 0);
        check("rst_rd_gt", rd_gt_o, 0);
        tick();
        rst_i   = 1'b0;
        seq_exp = 0;
        ndone   = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done_o) ndone++;
        end
        check("rst_no_done", ndone, 0);

        // Continuous mode, stop pulsed during the third window.
        set_chan(0, 100);
        win_log2_i   = 5'd2;
        threshold_i  = 11'd50;
        continuous_i = 1'b1;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        cyc     = 1;
        ndone   = 0;
        t_done  = '{0, 0, 0};
        while (cyc < 40) begin
            stop_i = (cyc == 18);
            tick();
            cyc++;
            if (done_o) begin
                if (ndone < 3) t_done[ndone] = cyc;
                ndone++;
            end
            if (cyc == 24) check("cont_busy_latch", busy_o, 1);
            if (cyc == 25) check("cont_busy_after", busy_o, 0);
        end
        stop_i = 1'b0;
        check("cont_ndone", ndone, 3);
        check("cont_done1", t_done[0], 9);
        check("cont_done2", t_done[1], 17);
        check("cont_done3", t_done[2], 25);
        check("cont_seq", seq_o, 3);
        read_bank(0, 0);
        check("cont_sq", rd_sq_o, 320000);
        check("cont_gt", rd_gt_o, 32);

        // Start and stop together in IDLE: exactly one window.
        continuous_i = 1'b1;
        start_i      = 1'b1;
        stop_i       = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        ndone   = 0;
        lat     = 0;
        for (int k = 2; k <= 40; k++) begin
            tick();
            if (done_o) begin
                ndone++;
                lat = k;
            end
        end
        check("ss_ndone", ndone, 1);
        check("ss_done_time", lat, 9);
        check("ss_busy", busy_o, 0);
        check("ss_seq", seq_o, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
